uart_tx_cfg: RTL and testbench

Runtime-configurable UART transmitter and the successor to the fixed 8N1 transmitter.
- Data length is selectable per frame: 5 to MAX_DATA_WIDTH bits.
- Parity is selectable per frame: none, even or odd.
- Stop bits are selectable per frame: 1 or 2.
- Data enters through a valid/ready handshake.
- The block sits between a TX FIFO or register interface and the pad. It shares the existing baud generator through sample_tick and baud_en.

---
 rtl/uart_tx_cfg.sv | 143 ++++++++++++++
 tb/tb_uart_tx_cfg.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter (5..MAX_DATA_WIDTH data
// bits, none/even/odd parity, 1 or 2 stop bits) with a valid/ready input and
// a shared baud generator driven through sample_tick / baud_en.
module uart_tx_cfg #(
  parameter int TICKS_PER_BIT  = 16,
  parameter int MAX_DATA_WIDTH = 9,
  localparam int CW = $clog2(MAX_DATA_WIDTH + 1),
  localparam int TW = $clog2(TICKS_PER_BIT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_tick,
  input  logic [MAX_DATA_WIDTH-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  input  logic [CW-1:0]             cfg_data_bits,
  input  logic [1:0]                cfg_parity,
  input  logic                      cfg_stop2,
  output logic                      tx_out,
  output logic                      tx_busy,
  output logic                      tx_done,
  output logic                      baud_en
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Per-frame settings captured at the handshake; frozen for the whole frame.
  typedef struct packed {
    logic [CW-1:0] nbits;
    logic          par_en;
    logic          par_bit;
    logic          stop2;
  } frame_cfg_t;

  state_t                    state, state_nxt;
  frame_cfg_t                cfg_q, cfg_d;
  logic [MAX_DATA_WIDTH-1:0] shreg;
  logic [TW-1:0]             tick_cnt;
  logic [CW-1:0]             bit_cnt;
  logic [CW-1:0]             n_clamp;
  logic                      par_x;
  logic                      hs, bit_end, last_data, last_stop;
  logic                      line_d, tx_done_nxt;

  assign tx_ready  = (state == IDLE);
  assign tx_busy   = (state != IDLE);
  assign hs        = tx_valid && tx_ready;
  assign bit_end   = (state != IDLE) && sample_tick && (tick_cnt == TW'(TICKS_PER_BIT - 1));
  assign last_data = (bit_cnt == cfg_q.nbits - CW'(1));
  assign last_stop = (bit_cnt == CW'(cfg_q.stop2));

  // Clamp requested length and fold parity over only the bits that will be sent.
  always_comb begin
    n_clamp = cfg_data_bits;
    if (cfg_data_bits < CW'(5))                   n_clamp = CW'(5);
    else if (cfg_data_bits > CW'(MAX_DATA_WIDTH)) n_clamp = CW'(MAX_DATA_WIDTH);
    par_x = 1'b0;
    for (int i = 0; i < MAX_DATA_WIDTH; i++)
      if (i < int'(n_clamp)) par_x = par_x ^ tx_data[i];
    cfg_d.nbits   = n_clamp;
    cfg_d.par_en  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    cfg_d.par_bit = (cfg_parity == 2'b10) ? ~par_x : par_x;
    cfg_d.stop2   = cfg_stop2;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; every non-idle transition happens on a bit boundary.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && last_data) state_nxt = cfg_q.par_en ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end && last_stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: line level for the current state and the completion strobe.
  always_comb begin
    line_d      = 1'b1;
    tx_done_nxt = 1'b0;
    case (state)
      START:   line_d = 1'b0;
      DATA:    line_d = shreg[0];
      PARITY:  line_d = cfg_q.par_bit;
      STOP:    tx_done_nxt = bit_end && last_stop;
      default: line_d = 1'b1;
    endcase
  end

  // Tick and bit counters; ticks only count while a frame is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (state == IDLE) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (sample_tick) begin
      tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
      if (bit_end) begin
        if ((state == DATA && !last_data) || (state == STOP && !last_stop))
          bit_cnt <= bit_cnt + CW'(1);
        else
          bit_cnt <= '0;
      end
    end
  end

  // Payload shift register and frame config capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cfg_q <= '0;
    end else if (hs) begin
      shreg <= tx_data;
      cfg_q <= cfg_d;
    end else if (state == DATA && bit_end) begin
      shreg <= shreg >> 1;
    end
  end

  // Registered pad outputs; each lags the state by one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_out  <= 1'b1;
      tx_done <= 1'b0;
      baud_en <= 1'b0;
    end else begin
      tx_out  <= line_d;
      tx_done <= tx_done_nxt;
      baud_en <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: samples the line mid-bit and checks frame
// length, handshake/done timing, baud_en gap and mid-frame reset.
module tb_uart_tx_cfg;

  localparam int T  = 16;
  localparam int MW = 9;
  localparam int CW = $clog2(MW + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sample_tick = 1'b0;
  logic [MW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [CW-1:0] cfg_data_bits;
  logic [1:0]    cfg_parity;
  logic          cfg_stop2;
  logic          tx_out, tx_busy, tx_done, baud_en;

  int n_chk  = 0;
  int n_fail = 0;
  int tdiv   = 0;

  uart_tx_cfg #(.TICKS_PER_BIT(T), .MAX_DATA_WIDTH(MW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done), .baud_en(baud_en)
  );

  always #5 clk = ~clk;

  // sample_tick every 4 clks, changed on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      sample_tick = (tdiv == 3);
      tdiv = (tdiv + 1) % 4;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One frame: handshake, mid-bit line samples, then completion checks.
  task automatic run_frame(input string tag, input logic [MW-1:0] data, input logic [CW-1:0] nb,
                           input logic [1:0] par, input logic s2, input logic [15:0] exp_bits,
                           input int nbit, input logic hold, input logic [MW-1:0] nxt);
    int ticks, cyc, pulses, rviol, bviol;
    @(negedge clk);
    tx_data = data; cfg_data_bits = nb; cfg_parity = par; cfg_stop2 = s2; tx_valid = 1'b1;
    chk($sformatf("%s_rdy", tag), tx_ready, 1);
    @(posedge clk); #1;
    chk($sformatf("%s_busy", tag), tx_busy, 1);
    chk($sformatf("%s_hs_line", tag), tx_out, 1);
    chk($sformatf("%s_hs_baud", tag), baud_en, 0);
    if (hold) tx_data = nxt;
    else begin
      tx_valid = 1'b0; tx_data = ~data;
      cfg_data_bits = CW'(9); cfg_parity = ~par; cfg_stop2 = ~s2;
    end
    ticks = 0; cyc = 0; pulses = 0; rviol = 0; bviol = 0;
    while (ticks < nbit * T && cyc < nbit * T * 4 + 100) begin
      @(posedge clk); #1;
      cyc++;
      if (sample_tick) ticks++;
      if (cyc == 1) chk($sformatf("%s_start_lag", tag), tx_out, 0);
      if (ticks < nbit * T) begin
        if (tx_ready) rviol++;
        if (!baud_en) bviol++;
        if (tx_done) pulses++;
        if (sample_tick && ticks % T == T / 2)
          chk($sformatf("%s_b%0d", tag, ticks / T), tx_out, exp_bits[ticks / T]);
      end
    end
    chk($sformatf("%s_len", tag), ticks, nbit * T);
    chk($sformatf("%s_rdy_low", tag), rviol, 0);
    chk($sformatf("%s_baud_hi", tag), bviol, 0);
    chk($sformatf("%s_early_done", tag), pulses, 0);
    chk($sformatf("%s_done", tag), tx_done, 1);
    chk($sformatf("%s_idle", tag), tx_ready, 1);
    chk($sformatf("%s_stop_line", tag), tx_out, 1);
    if (!hold) begin
      @(posedge clk); #1;
      chk($sformatf("%s_done_clr", tag), tx_done, 0);
      chk($sformatf("%s_baud_off", tag), baud_en, 0);
    end
  endtask

  initial begin
    int ticks, cyc, pulses;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0;
    cfg_data_bits = CW'(8); cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out",   tx_out,   1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy",  tx_busy,  0);
    chk("rst_done",  tx_done,  0);
    chk("rst_baud",  baud_en,  0);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_tick_ignored", tx_busy, 0);

    // 8N1 0xA5 : 0,1,0,1,0,0,1,0,1,1
    run_frame("8n1", 9'h0A5, CW'(8), 2'b00, 1'b0, 16'b1101001010, 10, 1'b0, '0);
    // 7E1 0x41 : 0,1,0,0,0,0,0,1,P=0,1
    run_frame("7e1", 9'h041, CW'(7), 2'b01, 1'b0, 16'b1010000010, 10, 1'b0, '0);
    // 8O2 0x00 : 0,0*8,P=1,1,1
    run_frame("8o2", 9'h000, CW'(8), 2'b10, 1'b1, 16'b111000000000, 12, 1'b0, '0);
    // N=3 clamps to 5, 0x1FF even : 0,1,1,1,1,1,P=1,1
    run_frame("clamp", 9'h1FF, CW'(3), 2'b01, 1'b0, 16'b11111110, 8, 1'b0, '0);
    // parity 11 behaves as none, N=15 clamps to 9 : 0x155 -> 0,1,0,1,0,1,0,1,0,1,1
    run_frame("clamp_hi", 9'h155, CW'(15), 2'b11, 1'b0, 16'b11010101010, 11, 1'b0, '0);
    // back-to-back 0x55 then 0xAA with tx_valid held high
    run_frame("b2b_a", 9'h055, CW'(8), 2'b00, 1'b0, 16'b1010101010, 10, 1'b1, 9'h0AA);
    run_frame("b2b_b", 9'h0AA, CW'(8), 2'b00, 1'b0, 16'b1101010100, 10, 1'b0, '0);

    // reset during data bit 3 of a 0xFF frame
    @(negedge clk);
    tx_data = 9'h0FF; cfg_data_bits = CW'(8); cfg_parity = 2'b00; cfg_stop2 = 1'b0; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    ticks = 0; cyc = 0;
    while (ticks < 4 * T + T / 2 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (sample_tick) ticks++;
    end
    chk("mid_busy", tx_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out",   tx_out,   1);
    chk("mid_rst_ready", tx_ready, 1);
    chk("mid_rst_busy",  tx_busy,  0);
    chk("mid_rst_baud",  baud_en,  0);
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (tx_done) pulses++;
    end
    chk("mid_no_done", pulses, 0);
    chk("mid_idle_line", tx_out, 1);
    // 0x0F after reset : 0,1,1,1,1,0,0,0,0,1
    run_frame("post_rst", 9'h00F, CW'(8), 2'b00, 1'b0, 16'b1000011110, 10, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
